// File: rtl/mdio_responder.sv
// Clause 22 MDIO responder (PHY side): decodes management frames
// oversampled from MDC and serves control, status, PHY ID and scratch words.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   mdc, mdio_i         management clock and pad input (asynchronous)
//   mdio_o, mdio_t      pad drive value and tristate (1 = released)
//   status_in           live word returned for register 1
//   ctrl_reg            register 0 contents
//   soft_reset          pulse when register 0 bit 15 is written as 1
//   wr_valid/addr/data  pulse plus address/data of every accepted write
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR   = 5'd1,
  parameter logic [15:0] PHY_ID1    = 16'h0141,
  parameter logic [15:0] PHY_ID2    = 16'h0CC0,
  parameter logic [15:0] CTRL_RESET = 16'h1140
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic [15:0] status_in,
  output logic [15:0] ctrl_reg,
  output logic        soft_reset,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  typedef enum logic [2:0] {
    IDLE, ST, OP, PHYAD, REGAD, TA, DATA
  } state_t;

  state_t      state;
  logic        mdc_s1, mdc_s2, mdc_d;
  logic        mdio_s1, mdio_s2;
  logic        rise;
  logic        bit_q;
  logic [5:0]  pre_cnt;
  logic [4:0]  k;
  logic [14:0] sh;
  logic        is_read;
  logic [4:0]  reg_addr;
  logic [15:0] rd_sh;
  logic [15:0] scratch [4];

  logic [4:0]  addr_now;
  logic [15:0] wdata;
  logic [15:0] rd_next;

  // Current sample appended to the bits already shifted in.
  assign addr_now = {sh[3:0], bit_q};
  assign wdata    = {sh, bit_q};

  always_comb begin
    rd_next = 16'h0000;
    if (addr_now[4:2] == 3'b100) begin
      rd_next = scratch[addr_now[1:0]];
    end else begin
      case (addr_now)
        5'd0:    rd_next = ctrl_reg;
        5'd1:    rd_next = status_in;
        5'd2:    rd_next = PHY_ID1;
        5'd3:    rd_next = PHY_ID2;
        default: rd_next = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      mdc_s1     <= 1'b0;
      mdc_s2     <= 1'b0;
      mdc_d      <= 1'b0;
      mdio_s1    <= 1'b1;
      mdio_s2    <= 1'b1;
      rise       <= 1'b0;
      bit_q      <= 1'b1;
      pre_cnt    <= 6'd0;
      k          <= 5'd0;
      sh         <= '0;
      is_read    <= 1'b0;
      reg_addr   <= 5'd0;
      rd_sh      <= 16'h0000;
      mdio_o     <= 1'b1;
      mdio_t     <= 1'b1;
      ctrl_reg   <= CTRL_RESET;
      soft_reset <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= 5'd0;
      wr_data    <= 16'h0000;
      for (int i = 0; i < 4; i++) scratch[i] <= 16'h0000;
    end else begin
      mdc_s1     <= mdc;
      mdc_s2     <= mdc_s1;
      mdc_d      <= mdc_s2;
      mdio_s1    <= mdio_i;
      mdio_s2    <= mdio_s1;
      // Edge detect and data sample are registered together so the
      // data bit stays aligned with the MDC edge it belongs to.
      rise       <= mdc_s2 & ~mdc_d;
      bit_q      <= mdio_s2;
      wr_valid   <= 1'b0;
      soft_reset <= 1'b0;
      if (rise) begin
        sh <= {sh[13:0], bit_q};
        unique case (state)
          IDLE: begin
            if (bit_q) begin
              if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
            end else if (pre_cnt == 6'd32) begin
              state   <= ST;
              pre_cnt <= 6'd0;
              k       <= 5'd1;
            end else begin
              pre_cnt <= 6'd0;
            end
          end
          ST: begin
            if (bit_q) begin
              state <= OP;
              k     <= 5'd2;
            end else begin
              state <= IDLE;
            end
          end
          OP: begin
            if (k == 5'd2) begin
              k <= 5'd3;
            end else if (sh[0] != bit_q) begin
              is_read <= sh[0];
              state   <= PHYAD;
              k       <= 5'd4;
            end else begin
              state <= IDLE;
            end
          end
          PHYAD: begin
            k <= k + 5'd1;
            if (k == 5'd8) begin
              state <= (addr_now == PHY_ADDR) ? REGAD : IDLE;
            end
          end
          REGAD: begin
            k <= k + 5'd1;
            if (k == 5'd13) begin
              reg_addr <= addr_now;
              rd_sh    <= rd_next;
              state    <= TA;
            end
          end
          TA: begin
            k <= k + 5'd1;
            if (k == 5'd14) begin
              if (is_read) begin
                mdio_t <= 1'b0;
                mdio_o <= 1'b0;
              end else if (!bit_q) begin
                state <= IDLE;
              end
            end else begin
              if (is_read) begin
                mdio_o <= rd_sh[15];
                rd_sh  <= {rd_sh[14:0], 1'b0};
                state  <= DATA;
              end else begin
                state <= bit_q ? IDLE : DATA;
              end
            end
          end
          DATA: begin
            k <= k + 5'd1;
            if (k == 5'd31) begin
              state <= IDLE;
              if (is_read) begin
                mdio_t <= 1'b1;
                mdio_o <= 1'b1;
              end else begin
                wr_valid <= 1'b1;
                wr_addr  <= reg_addr;
                wr_data  <= wdata;
                if (reg_addr == 5'd0) begin
                  // Bit 15 reloads defaults instead of storing.
                  if (wdata[15]) begin
                    ctrl_reg   <= CTRL_RESET;
                    soft_reset <= 1'b1;
                  end else begin
                    ctrl_reg <= wdata;
                  end
                end else if (reg_addr[4:2] == 3'b100) begin
                  scratch[reg_addr[1:0]] <= wdata;
                end
              end
            end else if (is_read) begin
              mdio_o <= rd_sh[15];
              rd_sh  <= {rd_sh[14:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: bit-banged station manager with a
// register-map reference model, directed cases then random frames.
module tb_mdio_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mdc = 1'b0;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_t;
  logic [15:0] status_in = 16'h0000;
  logic [15:0] ctrl_reg;
  logic        soft_reset;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  logic m_oe = 1'b0;
  logic m_val = 1'b1;

  // Open-drain style bus: pull-up when nobody drives.
  assign mdio_i = !mdio_t ? mdio_o : (m_oe ? m_val : 1'b1);

  always #10 clock = ~clock;

  mdio_responder #(
    .PHY_ADDR   (5'd1),
    .PHY_ID1    (16'h0141),
    .PHY_ID2    (16'h0CC0),
    .CTRL_RESET (16'h1140)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mdc        (mdc),
    .mdio_i     (mdio_i),
    .mdio_o     (mdio_o),
    .mdio_t     (mdio_t),
    .status_in  (status_in),
    .ctrl_reg   (ctrl_reg),
    .soft_reset (soft_reset),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  int errors = 0;
  int checks = 0;

  int          wv_cnt = 0;
  int          sr_cnt = 0;
  logic [4:0]  last_wa = '0;
  logic [15:0] last_wd = '0;

  always @(negedge clock) begin
    if (wr_valid) begin
      wv_cnt  = wv_cnt + 1;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (soft_reset) sr_cnt = sr_cnt + 1;
  end

  logic [15:0] m_ctrl;
  logic [15:0] m_scr [4];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 16'h1140;
    for (int i = 0; i < 4; i++) m_scr[i] = 16'h0000;
  endtask

  function automatic logic [15:0] model_rd(input logic [4:0] a,
                                           input logic [15:0] st);
    int ai;
    ai = int'(a);
    if (ai == 0) return m_ctrl;
    if (ai == 1) return st;
    if (ai == 2) return 16'h0141;
    if (ai == 3) return 16'h0CC0;
    if (ai >= 16 && ai <= 19) return m_scr[ai - 16];
    return 16'h0000;
  endfunction

  // One MDC period (400 ns); line sampled just before the rising edge.
  task automatic clk_bit(input logic drv, input logic v,
                         output logic smp, output logic tsmp);
    m_oe  = drv;
    m_val = v;
    #100;
    smp  = mdio_i;
    tsmp = mdio_t;
    mdc  = 1'b1;
    #200;
    mdc  = 1'b0;
    #100;
  endtask

  task automatic frame(input int pre, input logic [4:0] pa,
                       input logic [4:0] ra, input logic rd,
                       input logic [15:0] wd, input int rst_at,
                       output logic [15:0] rdata, output logic ta2,
                       output int tlow);
    logic s, t;
    logic [13:0] hdr;
    hdr   = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra};
    tlow  = 0;
    rdata = 16'h0000;
    ta2   = 1'b1;
    for (int i = 0; i < pre; i++) clk_bit(1'b1, 1'b1, s, t);
    for (int k = 0; k < 32; k++) begin
      if (k < 14) clk_bit(1'b1, hdr[13-k], s, t);
      else if (rd) clk_bit(1'b0, 1'b1, s, t);
      else if (k < 16) clk_bit(1'b1, (k == 14), s, t);
      else clk_bit(1'b1, wd[31-k], s, t);
      if (!t) tlow++;
      if (k == 15) ta2 = s;
      if (k >= 16) rdata[31-k] = s;
      if (k == 14) status_in = 16'($urandom);
      if (k == rst_at) begin
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_release", {31'd0, mdio_t}, 32'd1);
        reset = 1'b0;
        model_reset();
      end
    end
    m_oe = 1'b0;
  endtask

  task automatic do_read(input string tag, input int pre,
                         input logic [4:0] pa, input logic [4:0] ra,
                         input logic ans);
    logic [15:0] exp, got;
    logic ta2;
    int tl, w0;
    status_in = 16'($urandom);
    exp = model_rd(ra, status_in);
    w0  = wv_cnt;
    frame(pre, pa, ra, 1'b1, 16'h0000, -1, got, ta2, tl);
    if (ans) begin
      check({tag, "_data"}, {16'd0, got}, {16'd0, exp});
      check({tag, "_ta2"}, {31'd0, ta2}, 32'd0);
      check({tag, "_tlow"}, tl, 17);
      check({tag, "_rel"}, {31'd0, mdio_t}, 32'd1);
    end else begin
      check({tag, "_nodrive"}, tl, 0);
    end
    check({tag, "_nowr"}, wv_cnt - w0, 0);
  endtask

  task automatic do_write(input string tag, input int pre,
                          input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd);
    logic [15:0] got;
    logic ta2;
    int tl, w0, s0, ai;
    w0 = wv_cnt;
    s0 = sr_cnt;
    ai = int'(ra);
    frame(pre, pa, ra, 1'b0, wd, -1, got, ta2, tl);
    check({tag, "_tlow"}, tl, 0);
    if (pa == 5'd1) begin
      check({tag, "_wv"}, wv_cnt - w0, 1);
      check({tag, "_wa"}, {27'd0, last_wa}, {27'd0, ra});
      check({tag, "_wd"}, {16'd0, last_wd}, {16'd0, wd});
      check({tag, "_sr"}, sr_cnt - s0, (ai == 0 && wd[15]) ? 1 : 0);
      if (ai == 0) m_ctrl = wd[15] ? 16'h1140 : wd;
      if (ai >= 16 && ai <= 19) m_scr[ai - 16] = wd;
      check({tag, "_ctrl"}, {16'd0, ctrl_reg}, {16'd0, m_ctrl});
    end else begin
      check({tag, "_nowv"}, wv_cnt - w0, 0);
      check({tag, "_nosr"}, sr_cnt - s0, 0);
    end
  endtask

  initial begin
    logic [15:0] g;
    logic t2;
    int tl;
    logic [4:0] tab [9];
    logic [4:0] pa, ra;
    model_reset();
    tab = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd16, 5'd17, 5'd18, 5'd19, 5'd5};
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_t", {31'd0, mdio_t}, 32'd1);
    check("rst_o", {31'd0, mdio_o}, 32'd1);
    check("rst_ctrl", {16'd0, ctrl_reg}, 32'h1140);
    check("rst_wv", {31'd0, wr_valid}, 32'd0);
    check("rst_sr", {31'd0, soft_reset}, 32'd0);

    do_read("id1", 32, 5'd1, 5'd2, 1'b1);
    do_write("w17", 32, 5'd1, 5'd17, 16'hA5C3);
    do_read("r17", 32, 5'd1, 5'd17, 1'b1);
    do_read("pre31", 31, 5'd1, 5'd2, 1'b0);
    do_read("pre32", 32, 5'd1, 5'd2, 1'b1);
    do_read("badpa", 32, 5'd2, 5'd0, 1'b0);
    do_write("srst", 32, 5'd1, 5'd0, 16'h8000);
    do_read("r0", 32, 5'd1, 5'd0, 1'b1);
    do_read("id2", 32, 5'd1, 5'd3, 1'b1);

    frame(32, 5'd1, 5'd2, 1'b1, 16'h0000, 20, g, t2, tl);
    do_read("after_rst", 32, 5'd1, 5'd17, 1'b1);

    for (int n = 0; n < 24; n++) begin
      pa = ($urandom_range(5) == 0) ? 5'($urandom_range(31, 2)) : 5'd1;
      ra = tab[$urandom_range(8)];
      if (ra == 5'd5) ra = 5'($urandom);
      if ($urandom_range(1) == 0)
        do_write("rnd_w", 32 + $urandom_range(4), pa, ra, 16'($urandom));
      else
        do_read("rnd_r", 32 + $urandom_range(4), pa, ra, pa == 5'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
# mdio_responder

Clause 22 MDIO management responder (PHY side) for the Ethernet management bus. The existing design only drives `eth_mdc`/`eth_mdio` as station manager; this block answers read and write frames on that bus. It lets the board-level management path, or a loop-back bench, talk to our own PCS control and status words. It oversamples MDC in the system clock domain and holds a small register file: control, status, PHY ID and scratch.

## Interface
Parameters:
- `PHY_ADDR`, 5'd1: PHYAD this block answers to.
- `PHY_ID1`, 16'h0141: read-only value of register 2.
- `PHY_ID2`, 16'h0CC0: read-only value of register 3.
- `CTRL_RESET`, 16'h1140: reset and reload value of register 0.

Ports:
- `clock`, in, 1: system clock, ≥10× MDC frequency.
- `reset`, in, 1: synchronous, active-high.
- `mdc`, in, 1: management clock, asynchronous to `clock`, ≤2.5 MHz.
- `mdio_i`, in, 1: MDIO pad input, from the IOBUF O pin.
- `mdio_o`, out, 1: MDIO drive value, to the IOBUF I pin.
- `mdio_t`, out, 1: tristate enable; 1 = released (Z), 0 = driving.
- `status_in`, in, 16: live value returned for register 1.
- `ctrl_reg`, out, 16: current register 0 contents.
- `soft_reset`, out, 1: one-cycle pulse when register 0 bit 15 is written as 1.
- `wr_valid`, out, 1: one-cycle pulse on every accepted write to any address.
- `wr_addr`, out, 5: REGAD of the accepted write. Valid with `wr_valid`.
- `wr_data`, out, 16: data of the accepted write. Valid with `wr_valid`.

## Operation
- Sampling:
  - `mdc` and `mdio_i` each pass through a 2-flop synchronizer, on matched paths.
  - `rise` = synchronized `mdc` & ~(its delayed copy).
  - Every frame action happens only in a cycle where `rise` = 1.
- Frame bit index k counts from the first ST bit: k=0..1 ST, 2..3 OP, 4..8 PHYAD, 9..13 REGAD, 14..15 TA, 16..31 DATA (MSB first).
- States: IDLE, ST, OP, PHYAD, REGAD, TA, DATA.
- IDLE:
  - A 6-bit preamble counter increments on each sampled 1 and saturates at 32.
  - A sampled 0 with count = 32 moves to ST (this 0 is ST bit 0).
  - A sampled 0 with count < 32 clears the counter.
- ST: the sample must be 1, else go to IDLE.
- OP: 10 = read, 01 = write; 00 or 11 goes to IDLE.
- PHYAD: if the 5 bits ≠ `PHY_ADDR` at k=8, go to IDLE. Nothing is driven and nothing is written.
- REGAD: at k=13, latch the address and the read word `rd_word`.
- Read map:
  - 0 → `ctrl_reg`.
  - 1 → `status_in`, sampled at k=13.
  - 2 → `PHY_ID1`.
  - 3 → `PHY_ID2`.
  - 16..19 → scratch registers.
  - All other addresses → 16'h0000.
- Read drive sequence:
  - At k=14: `mdio_t`=0, `mdio_o`=0.
  - At k=15+j (j=0..15): `mdio_o` = `rd_word[15-j]`.
  - At k=31: `mdio_t`=1, go to IDLE.
  - The preamble counter is cleared at frame end.
- Write:
  - TA samples must be 1 then 0, else go to IDLE with no write.
  - DATA is shifted in over k=16..31.
  - At k=31, commit:
    - reg 0 ← data.
    - scratch 16..19 ← data.
    - Writes to registers 1, 2, 3 and unmapped addresses are discarded.
    - `wr_valid` pulses with `wr_addr`/`wr_data` for every address.
- Register 0 bit 15: a write with bit 15 = 1 pulses `soft_reset` and loads `ctrl_reg` ← `CTRL_RESET` instead of the written data. Bit 15 is therefore self-clearing.
- Simultaneous events: none are possible. `status_in` changes mid-read have no effect after k=13.

## Timing
- Reset values: `mdio_o`=1, `mdio_t`=1, `ctrl_reg`=`CTRL_RESET`, `soft_reset`=0, `wr_valid`=0, scratch=0, state IDLE, preamble count 0.
- Pin MDC rising edge → `rise` asserted 3 `clock` cycles later.
- `rise` cycle → `mdio_o`/`mdio_t` update registered on the next `clock` edge.
- Total drive latency ≤ 4 clocks + synchronizer uncertainty. This is within the 300 ns clock-to-output budget at `clock` ≥ 25 MHz.
- Write commit: `ctrl_reg`, scratch, `wr_valid` and `soft_reset` change 1 clock after the k=31 `rise`.
- Reset asserted mid-frame, including mid-read drive: `mdio_t`=1 on the next clock, state IDLE, and the counter must see a full new preamble.
- Back-to-back frames: the next frame needs 32 fresh preamble ones; there is no preamble suppression.

## Test plan
- Read ID, register 2 at PHYAD 1 with 32-bit preamble:
  - `mdio_t` goes low after the TA first-bit edge.
  - TA bit 2 reads 0.
  - Data reads 16'h0141.
  - `mdio_t`=1 after edge 31.
- Write 16'hA5C3 to register 17, then read register 17:
  - `wr_valid` pulses once with `wr_addr`=17, `wr_data`=16'hA5C3.
  - The readback returns 16'hA5C3.
- Read register 0 at PHYAD 2, with `PHY_ADDR`=1: `mdio_t` stays 1 for the whole frame; no `wr_valid`.
- Preamble of 31 ones, then a valid read of register 2: no drive. A following frame with 32 ones is answered normally.
- Write 16'h8000 to register 0:
  - `soft_reset` is high for exactly 1 cycle.
  - `ctrl_reg`=16'h1140.
  - A subsequent read returns 16'h1140.
- Assert `reset` at read bit k=20: `mdio_t`=1 on the next clock. The remaining edges are ignored and the next full frame is answered.
